// File: rtl/pll_scan_reconfig_if.sv
// Request/readback bus between a user block and the PLL scan-chain reconfiguration controller.
interface pll_scan_reconfig_if #(
  parameter int SCAN_LEN = 144
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic                cfg_write;
  logic [SCAN_LEN-1:0] cfg_image;
  logic [SCAN_LEN-1:0] rd_image;
  logic                done;
  logic                err;
  logic                busy;

  modport master (
    output cfg_valid, cfg_write, cfg_image,
    input  cfg_ready, rd_image, done, err, busy
  );

  modport slave (
    input  cfg_valid, cfg_write, cfg_image,
    output cfg_ready, rd_image, done, err, busy
  );
endinterface

// File: rtl/pll_scan_reconfig.sv
// altpll scan-chain controller: reads back the chain image, optionally shifts in and commits a new one.
// scanclk is generated from inclk0; each scanclk period starts on its falling edge.
module pll_scan_reconfig #(
  parameter int SCAN_LEN     = 144,
  parameter int CLK_DIV      = 2,
  parameter int DONE_TIMEOUT = 1024
) (
  input  logic               inclk0,
  input  logic               areset_n,
  pll_scan_reconfig_if.slave cfg,
  output logic               scanclk,
  output logic               scanclkena,
  output logic               scandata,
  output logic               scanread,
  output logic               scanwrite,
  output logic               scanaclr,
  input  logic               scandataout,
  input  logic               scandone
);

  localparam int PW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(SCAN_LEN + 1);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);

  localparam logic [PW-1:0] P_RISE = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] P_LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(SCAN_LEN - 1);
  localparam logic [BW-1:0] B_FULL = BW'(SCAN_LEN);
  localparam logic [TW-1:0] T_MAX  = TW'(DONE_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, READ, SHIFT, WRITE, WAIT_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       pcnt_q;
  logic [BW-1:0]       bcnt_q;
  logic [TW-1:0]       tcnt_q;
  logic [SCAN_LEN-1:0] img_q;
  logic [SCAN_LEN-1:0] rd_q;
  logic                wr_q;
  logic                sd_q;
  logic                ready_q, busy_q, done_q, err_q;
  logic                sclk_q, sclkena_q, sdata_q, sread_q, swrite_q;

  logic pend;     // this edge drives scanclk 1 -> 0 and closes the period
  logic accept;
  logic cap;      // sample scandataout and present the next bit
  logic fin;
  logic fin_err;

  assign pend = (pcnt_q == P_LAST);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    cap     = 1'b0;
    fin     = 1'b0;
    fin_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg.cfg_valid) begin
          state_d = READ;
          accept  = 1'b1;
        end
      end
      READ: begin
        if (pend) begin
          state_d = SHIFT;
          cap     = 1'b1;
        end
      end
      SHIFT: begin
        // The final period end captures nothing: every bit was sampled on a preceding falling edge.
        if (pend && bcnt_q < B_LAST) cap = 1'b1;
        if (pend && bcnt_q == B_LAST && wr_q) begin
          state_d = WRITE;
        end else if (bcnt_q == B_FULL) begin
          state_d = IDLE;
          fin     = 1'b1;
        end
      end
      WRITE: begin
        if (pend) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (sd_q) begin
          state_d = IDLE;
          fin     = 1'b1;
        end else if (tcnt_q == T_MAX) begin
          state_d = IDLE;
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge inclk0 or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      bcnt_q    <= '0;
      tcnt_q    <= '0;
      img_q     <= '0;
      rd_q      <= '0;
      wr_q      <= 1'b0;
      sd_q      <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sclk_q    <= 1'b0;
      sclkena_q <= 1'b0;
      sdata_q   <= 1'b0;
      sread_q   <= 1'b0;
      swrite_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sd_q      <= scandone;
      ready_q   <= (state_d == IDLE);
      busy_q    <= (state_d != IDLE);
      done_q    <= fin;
      sclkena_q <= (state_d != IDLE);
      sread_q   <= (state_d == READ);
      swrite_q  <= (state_d == WRITE);

      if (accept) begin
        wr_q  <= cfg.cfg_write;
        img_q <= cfg.cfg_image;
        err_q <= 1'b0;
      end else if (fin) begin
        err_q <= fin_err;
      end

      if (state_q == IDLE || state_d == IDLE) begin
        pcnt_q <= '0;
        sclk_q <= 1'b0;
      end else begin
        pcnt_q <= pend ? '0 : pcnt_q + 1'b1;
        if (pcnt_q == P_RISE) sclk_q <= 1'b1;
        else if (pend)        sclk_q <= 1'b0;
      end

      if (accept) bcnt_q <= '0;
      else if (state_q == SHIFT && pend && bcnt_q != B_FULL) bcnt_q <= bcnt_q + 1'b1;

      if (state_q == WRITE) tcnt_q <= '0;
      else if (state_q == WAIT_DONE && pend && tcnt_q != T_MAX) tcnt_q <= tcnt_q + 1'b1;

      // Read-only requests feed the captured bit straight back so the chain is left unchanged.
      if (cap) begin
        rd_q    <= (rd_q << 1) | SCAN_LEN'(scandataout);
        sdata_q <= wr_q ? img_q[SCAN_LEN-1] : scandataout;
        img_q   <= img_q << 1;
      end
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.busy      = busy_q;
  assign cfg.done      = done_q;
  assign cfg.err       = err_q;
  assign cfg.rd_image  = rd_q;
  assign scanclk       = sclk_q;
  assign scanclkena    = sclkena_q;
  assign scandata      = sdata_q;
  assign scanread      = sread_q;
  assign scanwrite     = swrite_q;
  assign scanaclr      = 1'b0;

endmodule

// File: tb/tb_pll_scan_reconfig.sv
// Directed bench for pll_scan_reconfig with a small 8-bit altpll scan-chain model.
module tb_pll_scan_reconfig;

  localparam int L = 8;

  logic inclk0   = 1'b0;
  logic areset_n = 1'b0;
  logic scanclk, scanclkena, scandata, scanread, scanwrite, scanaclr;
  logic scandataout, scandone;
  logic sd_block = 1'b0;

  pll_scan_reconfig_if #(.SCAN_LEN(L)) bus ();

  pll_scan_reconfig #(.SCAN_LEN(L), .CLK_DIV(2), .DONE_TIMEOUT(16)) dut (
    .inclk0      (inclk0),
    .areset_n    (areset_n),
    .cfg         (bus),
    .scanclk     (scanclk),
    .scanclkena  (scanclkena),
    .scandata    (scandata),
    .scanread    (scanread),
    .scanwrite   (scanwrite),
    .scanaclr    (scanaclr),
    .scandataout (scandataout),
    .scandone    (scandone)
  );

  always #5 inclk0 = ~inclk0;

  // PLL model: chain shifts on scanclk rise; scanread loads it from the active config,
  // scanwrite commits it, and scandone rises three periods after the commit.
  logic [7:0] chain    = 8'h3C;
  logic [7:0] pcfg     = 8'h3C;
  logic       sd_model = 1'b0;
  int         sd_cnt   = 0;

  always @(posedge scanclk) begin
    if (scanclkena) begin
      if (scanread) begin
        chain    <= pcfg;
        sd_model <= 1'b0;
      end else if (scanwrite) begin
        pcfg   <= chain;
        sd_cnt <= 3;
      end else begin
        chain <= {chain[6:0], scandata};
        if (sd_cnt > 0) begin
          sd_cnt <= sd_cnt - 1;
          if (sd_cnt == 1) sd_model <= 1'b1;
        end
      end
    end
  end

  assign scandataout = chain[7];
  assign scandone    = sd_model & ~sd_block;

  int swr_cnt  = 0;
  int done_cnt = 0;
  int ovl_cnt  = 0;

  always @(negedge inclk0) begin
    if (scanwrite) swr_cnt++;
    if (bus.done) done_cnt++;
    if (scanread && scanwrite) ovl_cnt++;
  end

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge inclk0);
    #1;
  endtask

  task automatic run_req(input logic w, input logic [7:0] img, output int lat);
    bus.cfg_write = w;
    bus.cfg_image = img;
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    chk("accept_ready_low", bus.cfg_ready, 0);
    chk("accept_busy", bus.busy, 1);
    chk("accept_err_clear", bus.err, 0);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
    if (bus.done !== 1'b1) lat = -1;
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] img;
    logic       blk;
    logic [7:0] exp_rd;
    logic [7:0] exp_cfg;
    logic       exp_err;
    int         exp_lat;   // 0: write with scandone, latency only bounded
    int         exp_swr;
  } vec_t;

  vec_t tv[4];

  initial begin
    int lat, s0, d0, o0, early, bad;
    logic [7:0] rd_hold;

    tv[0] = '{wr: 1'b0, img: 8'hFF, blk: 1'b0, exp_rd: 8'h3C, exp_cfg: 8'h3C, exp_err: 1'b0, exp_lat: 37,  exp_swr: 0};
    tv[1] = '{wr: 1'b1, img: 8'hA5, blk: 1'b0, exp_rd: 8'h3C, exp_cfg: 8'hA5, exp_err: 1'b0, exp_lat: 0,   exp_swr: 4};
    tv[2] = '{wr: 1'b1, img: 8'h5A, blk: 1'b1, exp_rd: 8'hA5, exp_cfg: 8'h5A, exp_err: 1'b1, exp_lat: 105, exp_swr: 4};
    tv[3] = '{wr: 1'b0, img: 8'h00, blk: 1'b0, exp_rd: 8'h5A, exp_cfg: 8'h5A, exp_err: 1'b0, exp_lat: 37,  exp_swr: 0};

    bus.cfg_valid = 1'b0;
    bus.cfg_write = 1'b0;
    bus.cfg_image = '0;
    repeat (3) tick();
    chk("rst_ready", bus.cfg_ready, 1);
    chk("rst_outs", {bus.busy, bus.done, bus.err, scanclk, scanclkena, scandata, scanread, scanwrite, scanaclr}, 9'h0);
    chk("rst_rd_image", bus.rd_image, 8'h00);
    areset_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_idle", {bus.cfg_ready, bus.busy, scanclk, scanclkena}, 4'b1000);

    for (int i = 0; i < 4; i++) begin
      sd_block = tv[i].blk;
      s0 = swr_cnt;
      run_req(tv[i].wr, tv[i].img, lat);
      if (tv[i].exp_lat > 0) chk("latency", lat, tv[i].exp_lat);
      else chk("write_done_window", (lat >= 41 && lat < 105), 1);
      chk("ready_with_done", bus.cfg_ready, 1);
      chk("rd_image", bus.rd_image, tv[i].exp_rd);
      chk("err", bus.err, tv[i].exp_err);
      chk("pll_config", pcfg, tv[i].exp_cfg);
      chk("scanwrite_cycles", swr_cnt - s0, tv[i].exp_swr);
      if (!tv[i].wr) chk("chain_restored", chain, tv[i].exp_cfg);
      rd_hold = bus.rd_image;
      tick();
      chk("done_one_cycle", bus.done, 0);
      repeat (9) tick();
      chk("rd_image_stable", bus.rd_image, rd_hold);
      chk("err_held", bus.err, tv[i].exp_err);
      sd_block = 1'b0;
    end

    // Back-to-back writes with cfg_valid held high
    s0 = swr_cnt;
    o0 = ovl_cnt;
    early = 0;
    bus.cfg_write = 1'b1;
    bus.cfg_image = 8'h11;
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_image = 8'h22;
    chk("b2b_first_busy", bus.busy, 1);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 400) begin
      tick();
      lat++;
      if (bus.cfg_ready && !bus.done) early++;
    end
    chk("b2b_first_done", bus.done, 1);
    chk("b2b_ready_only_at_done", early, 0);
    chk("b2b_rd1", bus.rd_image, 8'h5A);
    tick();
    bus.cfg_valid = 1'b0;
    chk("b2b_second_accepted", {bus.busy, bus.cfg_ready}, 2'b10);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
    chk("b2b_second_done", bus.done, 1);
    chk("b2b_rd2", bus.rd_image, 8'h11);
    chk("b2b_config", pcfg, 8'h22);
    chk("b2b_no_overlap", ovl_cnt - o0, 0);
    chk("b2b_scanwrite_cycles", swr_cnt - s0, 8);
    repeat (5) tick();

    // Asynchronous reset in the middle of SHIFT
    d0 = done_cnt;
    bus.cfg_write = 1'b0;
    bus.cfg_image = 8'h00;
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    repeat (19) tick();
    chk("mid_shift_busy", bus.busy, 1);
    areset_n = 1'b0;
    #1;
    chk("arst_ready", bus.cfg_ready, 1);
    chk("arst_outs", {bus.busy, bus.done, bus.err, scanclk, scanclkena, scandata, scanread, scanwrite, scanaclr}, 9'h0);
    chk("arst_rd_image", bus.rd_image, 8'h00);
    repeat (3) tick();
    areset_n = 1'b1;
    repeat (50) tick();
    chk("arst_no_done", done_cnt - d0, 0);
    run_req(1'b0, 8'hFF, lat);
    chk("post_arst_latency", lat, 37);
    chk("post_arst_rd", bus.rd_image, 8'h22);
    chk("post_arst_err", bus.err, 0);

    // Long idle period
    repeat (3) tick();
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (scanclk || scanclkena || scanread || scanwrite || bus.busy) bad++;
    end
    chk("idle_quiet", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/pll_scan_reconfig.md
# pll_scan_reconfig

Run-time reconfiguration controller for the enhanced `altpll` scan chain. It drives the PLL's scan ports (`scanclk`, `scanclkena`, `scandata`, `scanread`, `scanwrite`, `scanaclr`) and monitors `scandataout` and `scandone`. A user-side valid/ready request makes it read back the current chain image and, optionally, shift in a new N/M/counter image and commit it. It sits beside the generated PLL wrapper and is clocked from the same reference clock.

## Interface
- `SCAN_LEN`, 144: scan-chain length in bits.
- `CLK_DIV`, 2: `inclk0` cycles per `scanclk` half-period; must be 1 or greater.
- `DONE_TIMEOUT`, 1024: `scanclk` periods to wait for `scandone` before flagging an error.
- `inclk0` in 1: single clock. Every register is on its rising edge.
- `areset_n` in 1: asynchronous active-low reset.
- `cfg_valid` in 1: request strobe.
- `cfg_ready` out 1: controller is idle and can accept a request.
- `cfg_write` in 1: 1 means read back, then write and commit `cfg_image`. 0 means read back only.
- `cfg_image` in SCAN_LEN: new chain image, sampled on acceptance. Shifted MSB first.
- `rd_image` out SCAN_LEN: previous chain contents, captured MSB first.
- `done` out 1: one-cycle pulse when a request completes.
- `err` out 1: `scandone` timeout on the last request.
- `busy` out 1: inverse of `cfg_ready`.
- `scanclk`, `scanclkena`, `scandata`, `scanread`, `scanwrite`, `scanaclr` out 1: PLL scan drives.
- `scandataout`, `scandone` in 1: PLL scan returns.

## Operation
- A request is accepted on the edge where `cfg_valid && cfg_ready` is true. `cfg_image` and `cfg_write` are latched on that edge.
- While busy, `cfg_valid` is ignored.
- State machine: IDLE → READ → SHIFT → (WRITE → WAIT_DONE, only if `cfg_write`) → IDLE.
- **IDLE**: `scanclk` is held at 0, `scanclkena` = 0.
- **READ**: `scanread` = 1 for exactly one `scanclk` period, which contains one rising edge.
- **SHIFT**: lasts `SCAN_LEN` `scanclk` periods.
  - Bit `k` (MSB first) is presented on `scandata` starting at each falling edge.
  - `scandataout` is sampled on the `inclk0` edge that drives `scanclk` from 1 to 0, and shifted into `rd_image` from the LSB end.
  - When `cfg_write` = 0, the controller shifts the captured bits back in (recirculation), so the chain is restored unchanged.
- **WRITE**: `scanwrite` = 1 for one `scanclk` period.
- **WAIT_DONE**:
  - `scanclk` keeps toggling.
  - On the first `scandone` = 1: go to IDLE, pulse `done`, `err` = 0.
  - After `DONE_TIMEOUT` periods with no `scandone`: go to IDLE, pulse `done`, set `err` = 1.
- `err` holds its value until the next acceptance, which clears it.
- `scanaclr` is constantly 0.
- `scanclkena` = 1 in every state except IDLE.
- Counters: period counter width is clog2(CLK_DIV)+1, bit counter width is clog2(SCAN_LEN+1), timeout counter width is clog2(DONE_TIMEOUT+1). None of them may wrap.

## Timing
- Reset values:
  - `cfg_ready` = 1; `rd_image` = 0; state = IDLE.
  - All other outputs = 0: `busy`, `done`, `err`, `scanclk`, `scanclkena`, `scandata`, `scanread`, `scanwrite`, `scanaclr`.
- All outputs are registered. There are no combinational input-to-output paths.
- `cfg_ready` goes low on the cycle after acceptance.
- One `scanclk` period P = 2·CLK_DIV `inclk0` cycles. `scanclk` rises CLK_DIV cycles after entering READ.
- Read-only latency: `done` is high exactly (1+SCAN_LEN)·P + 1 cycles after the acceptance edge. `cfg_ready` returns high in the same cycle.
- Write latency: (2+SCAN_LEN)·P + 1 cycles + `scandone` wait.
  - `scandone` is sampled every `inclk0` cycle.
  - The return to IDLE is registered one cycle after `scandone` is seen.
- `rd_image` updates only during SHIFT and is stable from `done` until the next acceptance.
- Reset mid-operation: all outputs take their reset values immediately (asynchronous); the request is abandoned with no `done` pulse.

## Test plan
Settings: SCAN_LEN=8, CLK_DIV=2, DONE_TIMEOUT=16. The bench PLL chain model shifts on `scanclk` rising edges, is preloaded with 8'h3C, and asserts `scandone` 3 periods after `scanwrite`.
- Read-only request with `cfg_image` = 8'hFF → `rd_image` = 8'h3C, chain still 8'h3C, `scanwrite` never high, `done` exactly 37 cycles after acceptance.
- Write request with `cfg_image` = 8'hA5 → `rd_image` = 8'h3C, chain = 8'hA5, `scanwrite` high for 4 cycles, `done` pulse with `err` = 0.
- Write request with `scandone` tied to 0 → `done` pulses 16 `scanclk` periods after WRITE ends, `err` = 1. The next accepted request clears `err`.
- `cfg_valid` held high throughout two back-to-back write requests → the second request is accepted only on the cycle `cfg_ready` returns high. No overlap of `scanread`/`scanwrite`.
- `areset_n` pulsed low mid-SHIFT → all outputs at reset values within the same cycle, `scanclk` = 0, no `done` pulse. A new request after release completes normally.
- Idle check, no request for 100 cycles → `scanclk`, `scanclkena`, `scanread`, `scanwrite` remain 0.
